// File: rtl/ball_engine.sv
// Breakout game-state sequencer: moves the ball once per frame, resolves wall and
// paddle bounces, then walks the brick bitmap one brick per clock looking for a hit.
module ball_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_WIDTH = 64,
    parameter int BALL_SIZE    = 6,
    parameter int BALL_STEP    = 2,
    parameter int BRICK_ROWS   = 5,
    parameter int BRICK_COLS   = 10,
    parameter int BRICK_WIDTH  = 60,
    parameter int BRICK_HEIGHT = 18,
    parameter int BRICK_X0     = 20,
    parameter int BRICK_Y0     = 40,
    parameter int START_LIVES  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_tick,
    input  logic                             launch,
    input  logic [9:0]                       paddle_x,
    input  logic [9:0]                       paddle_y,
    output logic [9:0]                       ball_x,
    output logic [9:0]                       ball_y,
    output logic [BRICK_ROWS*BRICK_COLS-1:0] brick_state,
    output logic [7:0]                       score,
    output logic [1:0]                       lives,
    output logic [2:0]                       game_state
);
    localparam int N_BRICKS = BRICK_ROWS * BRICK_COLS;
    localparam int IDX_W    = $clog2(N_BRICKS + 1);

    localparam logic [10:0] SCR_W     = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H     = 11'(SCREEN_H);
    localparam logic [10:0] PAD_W     = 11'(PADDLE_WIDTH);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] STEP      = 11'(BALL_STEP);
    localparam logic [10:0] BRW       = 11'(BRICK_WIDTH);
    localparam logic [10:0] BRH       = 11'(BRICK_HEIGHT);
    localparam logic [10:0] BX0       = 11'(BRICK_X0);
    localparam logic [10:0] BY0       = 11'(BRICK_Y0);
    localparam logic [10:0] SERVE_OFS = 11'((PADDLE_WIDTH - BALL_SIZE) / 2);
    localparam logic [9:0]  STEP10    = 10'(BALL_STEP);
    localparam logic [9:0]  BSZ10     = 10'(BALL_SIZE);
    localparam logic [9:0]  XMAX10    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [7:0]  LAST_ROW  = 8'(BRICK_ROWS - 1);
    localparam logic [7:0]  LAST_COL  = 8'(BRICK_COLS - 1);
    localparam logic [1:0]  LIVES0    = 2'(START_LIVES);

    typedef enum logic [2:0] {
        ST_SERVE = 3'd0, ST_WAIT = 3'd1, ST_MOVE = 3'd2, ST_SCAN = 3'd3,
        ST_LOST  = 3'd4, ST_WIN  = 3'd5, ST_OVER = 3'd6
    } state_t;

    state_t              state_r, state_n;
    logic [9:0]          ball_x_r, ball_x_n, ball_y_r, ball_y_n;
    logic                dx_r, dx_n, dy_r, dy_n;   // 1 = positive direction (right / down)
    logic [N_BRICKS-1:0] bricks_r, bricks_n, cleared_s;
    logic [7:0]          score_r, score_n;
    logic [1:0]          lives_r, lives_n;
    logic [7:0]          row_r, row_n, col_r, col_n;
    logic [IDX_W-1:0]    idx_r, idx_n;
    logic [10:0]         bx_r, bx_n, by_r, by_n;

    logic [10:0] bx11_s, by11_s, px11_s, py11_s, serve_x_s;
    logic [9:0]  mv_x_s, mv_y_s;
    logic        mv_dx_s, mv_dy_s, mv_lost_s, pad_hit_s, scan_hit_s;

    assign bx11_s    = {1'b0, ball_x_r};
    assign by11_s    = {1'b0, ball_y_r};
    assign px11_s    = {1'b0, paddle_x};
    assign py11_s    = {1'b0, paddle_y};
    assign serve_x_s = px11_s + SERVE_OFS;

    assign pad_hit_s = (by11_s + BSZ <= py11_s) && (by11_s + STEP + BSZ >= py11_s) &&
                       (bx11_s < px11_s + PAD_W) && (bx11_s + BSZ > px11_s);

    assign scan_hit_s = bricks_r[idx_r] &&
                        (bx11_s < bx_r + BRW) && (bx11_s + BSZ > bx_r) &&
                        (by11_s < by_r + BRH) && (by11_s + BSZ > by_r);

    // One frame of ball motion, both axes computed from the current registers
    always_comb begin
        mv_x_s    = ball_x_r;
        mv_dx_s   = dx_r;
        mv_y_s    = ball_y_r;
        mv_dy_s   = dy_r;
        mv_lost_s = 1'b0;
        if (dx_r) begin
            if (bx11_s + STEP + BSZ >= SCR_W) begin
                mv_x_s  = XMAX10;
                mv_dx_s = 1'b0;
            end else begin
                mv_x_s = ball_x_r + STEP10;
            end
        end else begin
            if (bx11_s < STEP) begin
                mv_x_s  = 10'd0;
                mv_dx_s = 1'b1;
            end else begin
                mv_x_s = ball_x_r - STEP10;
            end
        end
        if (!dy_r) begin
            if (by11_s < STEP) begin
                mv_y_s  = 10'd0;
                mv_dy_s = 1'b1;
            end else begin
                mv_y_s = ball_y_r - STEP10;
            end
        end else if (pad_hit_s) begin
            mv_y_s  = paddle_y - BSZ10;
            mv_dy_s = 1'b0;
        end else if (by11_s + STEP + BSZ >= SCR_H) begin
            mv_lost_s = 1'b1;
        end else begin
            mv_y_s = ball_y_r + STEP10;
        end
    end

    // Bitmap with the brick under the scan pointer knocked out
    always_comb begin
        cleared_s        = bricks_r;
        cleared_s[idx_r] = 1'b0;
    end

    // Next-state and datapath update for the game sequencer
    always_comb begin
        state_n  = state_r;
        ball_x_n = ball_x_r;
        ball_y_n = ball_y_r;
        dx_n     = dx_r;
        dy_n     = dy_r;
        bricks_n = bricks_r;
        score_n  = score_r;
        lives_n  = lives_r;
        row_n    = row_r;
        col_n    = col_r;
        idx_n    = idx_r;
        bx_n     = bx_r;
        by_n     = by_r;
        case (state_r)
            ST_SERVE: begin
                ball_x_n = (serve_x_s > 11'd1023) ? 10'h3FF : serve_x_s[9:0];
                ball_y_n = (paddle_y >= BSZ10) ? (paddle_y - BSZ10) : 10'd0;
                if (launch) begin
                    dx_n    = 1'b1;
                    dy_n    = 1'b0;
                    state_n = ST_WAIT;
                end else begin
                    state_n = ST_SERVE;
                end
            end
            ST_WAIT: begin
                if (frame_tick) begin
                    state_n = ST_MOVE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_MOVE: begin
                if (mv_lost_s) begin
                    state_n = ST_LOST;
                end else begin
                    ball_x_n = mv_x_s;
                    ball_y_n = mv_y_s;
                    dx_n     = mv_dx_s;
                    dy_n     = mv_dy_s;
                    row_n    = 8'd0;
                    col_n    = 8'd0;
                    idx_n    = '0;
                    bx_n     = BX0;
                    by_n     = BY0;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_hit_s) begin
                    bricks_n = cleared_s;
                    score_n  = score_r + 8'd1;
                    dy_n     = ~dy_r;
                    state_n  = (cleared_s == '0) ? ST_WIN : ST_WAIT;
                end else if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
                    state_n = ST_WAIT;
                end else begin
                    idx_n = idx_r + 1'b1;
                    // Box corners tracked incrementally, row-major order
                    if (col_r == LAST_COL) begin
                        col_n = 8'd0;
                        row_n = row_r + 8'd1;
                        bx_n  = BX0;
                        by_n  = by_r + BRH;
                    end else begin
                        col_n = col_r + 8'd1;
                        bx_n  = bx_r + BRW;
                    end
                end
            end
            ST_LOST: begin
                lives_n = lives_r - 2'd1;
                state_n = (lives_r == 2'd1) ? ST_OVER : ST_SERVE;
            end
            ST_WIN, ST_OVER: begin
                if (launch) begin
                    bricks_n = {N_BRICKS{1'b1}};
                    score_n  = 8'd0;
                    lives_n  = LIVES0;
                    state_n  = ST_SERVE;
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_SERVE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_SERVE;
        end else begin
            state_r <= state_n;
        end
    end

    // Game datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ball_x_r <= 10'd0;
            ball_y_r <= 10'd0;
            dx_r     <= 1'b1;
            dy_r     <= 1'b0;
            bricks_r <= {N_BRICKS{1'b1}};
            score_r  <= 8'd0;
            lives_r  <= LIVES0;
            row_r    <= 8'd0;
            col_r    <= 8'd0;
            idx_r    <= '0;
            bx_r     <= BX0;
            by_r     <= BY0;
        end else begin
            ball_x_r <= ball_x_n;
            ball_y_r <= ball_y_n;
            dx_r     <= dx_n;
            dy_r     <= dy_n;
            bricks_r <= bricks_n;
            score_r  <= score_n;
            lives_r  <= lives_n;
            row_r    <= row_n;
            col_r    <= col_n;
            idx_r    <= idx_n;
            bx_r     <= bx_n;
            by_r     <= by_n;
        end
    end

    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;
    assign brick_state = bricks_r;
    assign score       = score_r;
    assign lives       = lives_r;
    assign game_state  = state_r;

endmodule
